// File: rtl/stopwatch_pkg.sv
// +----------------------------------------------------------------------------
// | stopwatch_pkg : state encoding shared by the stopwatch controller blocks
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    PAUSE   = 2'b10,
    ILLEGAL = 2'b11
  } sw_state_t;

endpackage

`default_nettype wire

// File: rtl/btn_filter.sv
// +----------------------------------------------------------------------------
// | btn_filter : 2-FF synchronizer, stable-level debounce, one-cycle press pulse
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module btn_filter #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);

  logic       sync_q1;
  logic       sync_q2;
  logic [7:0] stable_cnt;
  logic       level;
  logic       level_d;

  // stable_cnt counts consecutive samples that disagree with the accepted level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1    <= 1'b0;
      sync_q2    <= 1'b0;
      stable_cnt <= 8'd0;
      level      <= 1'b0;
      level_d    <= 1'b0;
      press      <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
      if (sync_q2 == level) begin
        stable_cnt <= 8'd0;
      end else if (stable_cnt == LAST_CNT) begin
        level      <= sync_q2;
        stable_cnt <= 8'd0;
      end else begin
        stable_cnt <= stable_cnt + 8'd1;
      end
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// +----------------------------------------------------------------------------
// | stopwatch_ctrl : debounced start/clear/lap buttons driving a run/pause FSM
// | Optional lap feature: define STOPWATCH_CTRL_LAP_EN.   Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_lap,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       lap_hold,
  output logic [1:0] state
);

  sw_state_t state_q;
  logic      start_press;
  logic      clear_press;
  logic      lap_press;

  btn_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_start_filter (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_start),
    .press   (start_press)
  );

  btn_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_clear_filter (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_clear),
    .press   (clear_press)
  );

`ifdef STOPWATCH_CTRL_LAP_EN
  logic lap_q;

  btn_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_lap_filter (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_lap),
    .press   (lap_press)
  );

  assign lap_hold = lap_q;
`else
  logic unused_lap;

  assign lap_press  = 1'b0;
  assign unused_lap = btn_lap;
  assign lap_hold   = 1'b0;
`endif

  // cnt_en is updated alongside state_q so it is high exactly while in RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_en  <= 1'b0;
      cnt_clr <= 1'b0;
`ifdef STOPWATCH_CTRL_LAP_EN
      lap_q   <= 1'b0;
`endif
    end else begin
      cnt_clr <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_press) begin
            state_q <= RUN;
            cnt_en  <= 1'b1;
          end
        end
        RUN: begin
`ifdef STOPWATCH_CTRL_LAP_EN
          if (lap_press) lap_q <= ~lap_q;
`endif
          if (start_press) begin
            state_q <= PAUSE;
            cnt_en  <= 1'b0;
          end
        end
        PAUSE: begin
`ifdef STOPWATCH_CTRL_LAP_EN
          if (lap_press) lap_q <= 1'b0;
`endif
          if (clear_press) begin
            state_q <= IDLE;
            cnt_clr <= 1'b1;
`ifdef STOPWATCH_CTRL_LAP_EN
            lap_q   <= 1'b0;
`endif
          end else if (start_press) begin
            state_q <= RUN;
            cnt_en  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_en  <= 1'b0;
`ifdef STOPWATCH_CTRL_LAP_EN
          lap_q   <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign state = state_q;

endmodule

`default_nettype wire

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, number of consecutive equal synchronized samples needed to accept a button level (legal 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port btn_start, input, 1, raw asynchronous start/stop button.
REQ-005 SHALL have port btn_clear, input, 1, raw asynchronous clear button.
REQ-006 SHALL have port btn_lap, input, 1, raw asynchronous lap button.
REQ-007 SHALL have port cnt_en, output, 1, counter enable; high while in RUN.
REQ-008 SHALL have port cnt_clr, output, 1, one-cycle counter clear pulse.
REQ-009 SHALL have port lap_hold, output, 1, display-freeze level.
REQ-010 SHALL have port state, output, 2, current FSM state encoding.

Function
REQ-011 SHALL condition each button with a 2-FF synchronizer, then a stable counter; the filtered level updates only after STABLE_CYCLES consecutive identical synchronized samples.
REQ-012 SHALL emit a one-cycle press pulse per button on a filtered 0->1 transition; release produces no pulse.
REQ-013 SHALL produce the press pulse 2+STABLE_CYCLES edges after the first edge sampling a stably-held raw button high; glitches shorter than STABLE_CYCLES cycles produce no pulse.
REQ-014 SHALL implement states IDLE=2'b00, RUN=2'b01, PAUSE=2'b10; 2'b11 is illegal and SHALL return to IDLE on the next edge.
REQ-015 SHALL transition IDLE->RUN on start press; RUN->PAUSE on start press; PAUSE->RUN on start press; PAUSE->IDLE on clear press.
REQ-016 SHALL ignore clear presses in IDLE and RUN.
REQ-017 SHALL give clear priority over start when both press pulses coincide in PAUSE (go to IDLE).
REQ-018 SHALL assert cnt_clr for exactly one cycle, the cycle after the PAUSE->IDLE transition edge.
REQ-019 SHALL drive cnt_en, cnt_clr, lap_hold and state from registers; cnt_en high exactly in cycles where state==RUN.
REQ-020 SHALL toggle lap_hold on lap press in RUN, clear lap_hold on lap press in PAUSE, and ignore lap in IDLE.
REQ-021 SHALL clear lap_hold on entry to IDLE.

Reset
REQ-022 SHALL, while reset is high at a clock edge, set state=IDLE, cnt_en=0, cnt_clr=0, lap_hold=0, synchronizers, stable counters and filtered levels to 0.
REQ-023 SHALL, if a button is held through reset deassertion, generate a press once it passes the filter (filtered level starts at 0).
REQ-024 SHALL abort any in-progress RUN/PAUSE on reset without emitting cnt_clr.

Configuration
REQ-025 SHALL compile the lap feature only when macro STOPWATCH_CTRL_LAP_EN is defined.
REQ-026 SHALL, without STOPWATCH_CTRL_LAP_EN, omit the btn_lap filter, keep port btn_lap (ignored) and tie lap_hold to 0.

Structure
REQ-027 SHALL take the state typedef and IDLE/RUN/PAUSE encodings from shared package stopwatch_pkg.
REQ-028 SHALL instantiate sub-module btn_filter (synchronizer + stable counter + press pulse) once per button, parameterized by STABLE_CYCLES.

Verification
REQ-029 SHALL cover: reset, btn_start held high 20 cycles (STABLE_CYCLES=4) -> one press pulse 6 edges after first high sample; state 00->01; cnt_en=1.
REQ-030 SHALL cover: 3-cycle btn_start glitch in IDLE -> no pulse; state stays 00.
REQ-031 SHALL cover: RUN, start press -> PAUSE (10), cnt_en=0; clear press -> IDLE, cnt_clr high exactly 1 cycle.
REQ-032 SHALL cover: PAUSE, start and clear pressed same cycle -> IDLE, cnt_clr pulse, cnt_en stays 0.
REQ-033 SHALL cover: with STOPWATCH_CTRL_LAP_EN, lap press twice in RUN -> lap_hold 1 then 0; without it, lap_hold constant 0.
REQ-034 SHALL cover: reset asserted mid-RUN with lap_hold=1 -> next edge state=00, cnt_en=0, lap_hold=0, cnt_clr=0.
